// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: four-requester round-robin arbiter with grant locking.
// A granted requester keeps the resource until it drops req or pulses done.
// Every release is followed by one idle turnaround cycle before the next grant.
// Optional hold limit: define ARB_TIMEOUT_EN to end a tenure after MAX_HOLD cycles.
// When the limit ends a tenure, timeout pulses for one cycle.
module rr_lock_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_vld,
    output logic [1:0]       gnt_id,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               gnt_vld_q, gnt_vld_d;
    logic [1:0]         gnt_id_q, gnt_id_d;
    logic [1:0]         last_id_q, last_id_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               timeout_q, timeout_d;

    logic               sel_vld;
    logic [1:0]         sel_id;
    logic               owner_req;
    logic               owner_done;
    logic               hold_hit;

    // Rotating-priority search: start just above last_id, so last_id ranks lowest.
    always_comb begin
        sel_vld = 1'b0;
        sel_id  = last_id_q;
        // Walk from the lowest-priority slot towards the highest; the last hit wins.
        for (int k = 4; k >= 1; k--) begin
            if (req[last_id_q + 2'(k)]) begin
                sel_vld = 1'b1;
                sel_id  = last_id_q + 2'(k);
            end
        end
    end

    assign owner_req  = req[gnt_id_q];
    assign owner_done = done[gnt_id_q];
    assign hold_hit   = TIMEOUT_EN && (hold_cnt_q == HOLD_LAST);

    // Next-state and next-output logic for the IDLE / GRANT / GAP controller.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_vld_d  = gnt_vld_q;
        gnt_id_d   = gnt_id_q;
        last_id_d  = last_id_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;

        case (state_q)
            IDLE, GAP: begin
                if (sel_vld) begin
                    state_d    = GRANT;
                    gnt_d      = N_REQ'(1) << sel_id;
                    gnt_vld_d  = 1'b1;
                    gnt_id_d   = sel_id;
                    hold_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!owner_req || owner_done || hold_hit) begin
                    state_d   = GAP;
                    gnt_d     = '0;
                    gnt_vld_d = 1'b0;
                    last_id_d = gnt_id_q;
                    // A tenure ended by req drop or done is not a timeout.
                    timeout_d = hold_hit && owner_req && !owner_done;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_d     = '0;
                gnt_vld_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops the grant asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_vld_q  <= 1'b0;
            gnt_id_q   <= 2'd3;
            last_id_q  <= 2'd3;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_vld_q  <= gnt_vld_d;
            gnt_id_q   <= gnt_id_d;
            last_id_q  <= last_id_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vld = gnt_vld_q;
    assign gnt_id  = gnt_id_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Self-checking bench for rr_lock_arbiter.
// Phase 1: a vector table of directed stimulus with expected values.
// Phase 2: hand-written sequences for reset mid-tenure and the hold limit.
// Phase 3: random stimulus checked against a tenure-level reference model.
module tb_rr_lock_arbiter;

    localparam int TB_MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic       gnt_vld;
    logic [1:0] gnt_id;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    rr_lock_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] gnt;
        logic [1:0] id;
    } vec_t;

    vec_t vq[$];

    // Reference model state: owner index (-1 = nobody), last releaser, reported id.
    int m_owner;
    int m_last;
    int m_id;
    int m_held;
    bit m_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g, input logic [1:0] id);
        vec_t v;
        v.req  = r;
        v.done = d;
        v.gnt  = g;
        v.id   = id;
        vq.push_back(v);
    endtask

    // Apply inputs, let one rising edge happen, and settle 1 unit past it.
    task automatic step(input logic [3:0] r, input logic [3:0] d);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] g, input logic [1:0] id, input logic to);
        check({tag, ".gnt"},     32'(gnt),     32'(g));
        check({tag, ".gnt_vld"}, 32'(gnt_vld), 32'(|g));
        check({tag, ".gnt_id"},  32'(gnt_id),  32'(id));
        check({tag, ".timeout"}, 32'(timeout), 32'(to));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0;
        done  = 4'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 4'b0000, 2'd3, 1'b0);
        rst_n = 1'b1;
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_last  = 3;
        m_id    = 3;
        m_held  = 0;
        m_to    = 1'b0;
    endfunction

    // One clock of the arbiter seen as tenures: an owner keeps the resource until
    // it lets go; the edge after a release is the turnaround, so a new owner is
    // only picked on an edge where nobody owns the resource.
    function automatic void model_step(input logic [3:0] r, input logic [3:0] d);
        bit limit;
        bit found;
        int cand;
        limit = 1'b0;
        found = 1'b0;
        m_to  = 1'b0;
        if (m_owner >= 0) begin
            m_held = m_held + 1;
`ifdef ARB_TIMEOUT_EN
            limit = (m_held >= TB_MAX_HOLD);
`endif
            if (!r[m_owner] || d[m_owner] || limit) begin
                m_to    = limit && r[m_owner] && !d[m_owner];
                m_last  = m_owner;
                m_owner = -1;
            end
        end else begin
            for (int off = 1; off <= 4; off++) begin
                cand = (m_last + off) % 4;
                if (!found && r[cand]) begin
                    found   = 1'b1;
                    m_owner = cand;
                    m_id    = cand;
                    m_held  = 0;
                end
            end
        end
    endfunction

    initial begin
        logic [3:0] r;
        logic [3:0] d;
        logic [3:0] g_exp;

        rst_n = 1'b0;
        req   = 4'b0;
        done  = 4'b0;
        do_reset();

        // Single requester 2, released by done, then idle.
        add(4'b0100, 4'b0000, 4'b0100, 2'd2);
        add(4'b0100, 4'b0000, 4'b0100, 2'd2);
        add(4'b0100, 4'b0000, 4'b0100, 2'd2);
        add(4'b0100, 4'b0100, 4'b0000, 2'd2);
        add(4'b0000, 4'b0000, 4'b0000, 2'd2);
        add(4'b0000, 4'b0000, 4'b0000, 2'd2);
        // All requesting, last=2: order 3,0,1,2,3, two-cycle tenures with a gap.
        add(4'b1111, 4'b0000, 4'b1000, 2'd3);
        add(4'b1111, 4'b0000, 4'b1000, 2'd3);
        add(4'b1111, 4'b1000, 4'b0000, 2'd3);
        add(4'b1111, 4'b0000, 4'b0001, 2'd0);
        add(4'b1111, 4'b0000, 4'b0001, 2'd0);
        add(4'b1111, 4'b0001, 4'b0000, 2'd0);
        add(4'b1111, 4'b0000, 4'b0010, 2'd1);
        add(4'b1111, 4'b0000, 4'b0010, 2'd1);
        add(4'b1111, 4'b0010, 4'b0000, 2'd1);
        add(4'b1111, 4'b0000, 4'b0100, 2'd2);
        add(4'b1111, 4'b0000, 4'b0100, 2'd2);
        add(4'b1111, 4'b0100, 4'b0000, 2'd2);
        add(4'b1111, 4'b0000, 4'b1000, 2'd3);
        add(4'b1111, 4'b0000, 4'b1000, 2'd3);
        add(4'b1111, 4'b1000, 4'b0000, 2'd3);
        // Releasing owner 1 is re-granted only when it is the sole requester.
        add(4'b0010, 4'b0000, 4'b0010, 2'd1);
        add(4'b0010, 4'b0010, 4'b0000, 2'd1);
        add(4'b0010, 4'b0000, 4'b0010, 2'd1);
        add(4'b1010, 4'b0010, 4'b0000, 2'd1);
        add(4'b1010, 4'b0000, 4'b1000, 2'd3);
        add(4'b0000, 4'b0000, 4'b0000, 2'd3);
        add(4'b0000, 4'b0000, 4'b0000, 2'd3);
        // Owner 0 ignores a non-owner done and a new req[3]; released by req[0] drop.
        add(4'b0001, 4'b0000, 4'b0001, 2'd0);
        add(4'b1001, 4'b0100, 4'b0001, 2'd0);
        add(4'b1001, 4'b0000, 4'b0001, 2'd0);
        add(4'b1000, 4'b0000, 4'b0000, 2'd0);
        add(4'b1000, 4'b0000, 4'b1000, 2'd3);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].req, vq[i].done);
            check_outputs($sformatf("vec%0d", i), vq[i].gnt, vq[i].id, 1'b0);
        end

        // Reset mid-tenure: grant drops without waiting for a clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs("async_reset", 4'b0000, 2'd3, 1'b0);
        req = 4'b1001;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b1001, 4'b0000);
        check_outputs("post_reset", 4'b0001, 2'd0, 1'b0);

        // Hold limit with two requesters and no done.
        do_reset();
`ifdef ARB_TIMEOUT_EN
        for (int e = 0; e < TB_MAX_HOLD; e++) begin
            step(4'b0011, 4'b0000);
            check_outputs($sformatf("hold%0d", e), 4'b0001, 2'd0, 1'b0);
        end
        step(4'b0011, 4'b0000);
        check_outputs("timeout_gap", 4'b0000, 2'd0, 1'b1);
        step(4'b0011, 4'b0000);
        check_outputs("after_timeout", 4'b0010, 2'd1, 1'b0);
`else
        for (int e = 0; e < 120; e++) begin
            step(4'b0011, 4'b0000);
            check(
                $sformatf("nolimit%0d", e),
                {27'd0, timeout, gnt},
                {27'd0, 1'b0, 4'b0001}
            );
        end
`endif

        // Random traffic against the reference model.
        do_reset();
        model_reset();
        r = 4'b0;
        for (int c = 0; c < 3000; c++) begin
            r = r ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
            d = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            step(r, d);
            model_step(r, d);
            g_exp = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            check_outputs($sformatf("rand%0d", c), g_exp, 2'(m_id), m_to);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
